// File: rtl/prm_chk_pkg.sv
// Shared types and defaults for the PRM obstacle scan controller and its bench.
// Checker inputs are lettered A (bit 0) through O (bit 14).
package prm_chk_pkg;

    localparam int unsigned CODE_W_DEF    = 15;
    localparam int unsigned NUM_EDGES_DEF = 256;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } scan_state_e;

    // Letter of the checker input driven by code bit idx, '?' when out of range.
    function automatic byte chk_letter(input int unsigned idx);
        if (idx < CODE_W_DEF) begin
            chk_letter = byte'(8'h41 + idx[7:0]);
        end else begin
            chk_letter = 8'h3F;
        end
    endfunction

endpackage

// File: rtl/prm_mask_accum.sv
// Sticky blocked-edge bitmap with clear/OR merge and a registered word readout.
// Clear takes priority over a merge arriving on the same edge.
module prm_mask_accum
    import prm_chk_pkg::*;
#(
    parameter int unsigned NUM_EDGES = NUM_EDGES_DEF,
    parameter int unsigned RD_W      = 32,
    localparam int unsigned NumWords = NUM_EDGES / RD_W,
    localparam int unsigned AddrW    = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 merge_i,
    input  logic [NUM_EDGES-1:0] mask_i,
    input  logic [AddrW-1:0]     rd_addr_i,
    output logic [RD_W-1:0]      rd_data_o,
    output logic                 any_blocked_o
);

    logic [NUM_EDGES-1:0] bitmap_q, bitmap_d;
    logic                 any_q, any_d;
    logic [RD_W-1:0]      rd_q, rd_word;

    always_comb begin
        bitmap_d = bitmap_q;
        any_d    = any_q;
        if (clear_i) begin
            bitmap_d = '0;
            any_d    = 1'b0;
        end else if (merge_i) begin
            bitmap_d = bitmap_q | mask_i;
            any_d    = any_q | (|mask_i);
        end
    end

    // Addresses with no matching word fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned w = 0; w < NumWords; w++) begin
            if (rd_addr_i == AddrW'(w)) begin
                rd_word = bitmap_q[w*RD_W +: RD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q <= '0;
            any_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            bitmap_q <= bitmap_d;
            any_q    <= any_d;
            rd_q     <= rd_word;
        end
    end

    assign rd_data_o     = rd_q;
    assign any_blocked_o = any_q;

endmodule

// File: rtl/prm_obstacle_scan_ctrl.sv
// Streams obstacle codes onto the PRM checker bus and collects the returned edge masks
// into a sticky blocked-edge bitmap readable by the roadmap planner.
module prm_obstacle_scan_ctrl
    import prm_chk_pkg::*;
#(
    parameter int unsigned CODE_W    = CODE_W_DEF,
    parameter int unsigned NUM_EDGES = NUM_EDGES_DEF,
    parameter int unsigned RD_W      = 32,
    parameter int unsigned CHK_LAT   = 1,
    localparam int unsigned NumWords = NUM_EDGES / RD_W,
    localparam int unsigned AddrW    = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 obs_valid_i,
    output logic                 obs_ready_o,
    input  logic [CODE_W-1:0]    obs_code_i,
    input  logic                 obs_last_i,
    output logic [CODE_W-1:0]    chk_code_o,
    input  logic [NUM_EDGES-1:0] chk_mask_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 any_blocked_o,
    output logic [15:0]          obs_count_o,
    input  logic [AddrW-1:0]     rd_addr_i,
    output logic [RD_W-1:0]      rd_data_o
);

    scan_state_e         state_q, state_d;
    logic [CHK_LAT:0]    tok_q, tok_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                accept;

    // start wins over a beat offered in the same cycle.
    assign obs_ready_o = (state_q == StScan) && !start_i;
    assign accept      = obs_ready_o && obs_valid_i;

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        // Token slot CHK_LAT lines up with the checker mask for the code that spawned it.
        tok_d[0] = accept;
        for (int unsigned i = 1; i <= CHK_LAT; i++) begin
            tok_d[i] = tok_q[i-1];
        end

        if (accept) begin
            code_d = obs_code_i;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        case (state_q)
            StIdle, StDone: ;
            StScan: begin
                if (accept && obs_last_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (tok_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_i) begin
            state_d = StScan;
            tok_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tok_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    prm_mask_accum #(
        .NUM_EDGES (NUM_EDGES),
        .RD_W      (RD_W)
    ) u_accum (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (start_i),
        .merge_i       (tok_q[CHK_LAT]),
        .mask_i        (chk_mask_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .any_blocked_o (any_blocked_o)
    );

    assign chk_code_o  = code_q;
    assign busy_o      = (state_q == StScan) || (state_q == StDrain);
    assign done_o      = done_q;
    assign obs_count_o = cnt_q;

endmodule

// File: tb/tb_prm_obstacle_scan_ctrl.sv
// Bench for prm_obstacle_scan_ctrl: event-queue model checked every cycle against the
// CHK_LAT=1 instance, plus CHK_LAT=0/4 instances compared on a repeated frame.
module tb_prm_obstacle_scan_ctrl;
    import prm_chk_pkg::*;

    localparam int unsigned LAT1 = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        obs_valid;
    logic [14:0] obs_code;
    logic        obs_last;
    logic [2:0]  rd_addr;

    logic         ready0, ready1, ready4;
    logic [14:0]  code0, code1, code4;
    logic [255:0] mask0, mask1, mask4;
    logic         busy0, busy1, busy4;
    logic         done0, done1, done4;
    logic         any0, any1, any4;
    logic [15:0]  cnt0, cnt1, cnt4;
    logic [31:0]  rd0, rd1, rd4;
    logic [255:0] d4 [4];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    function automatic logic [255:0] onehot(input logic [7:0] b);
        logic [255:0] one;
        one = 256'd1;
        return one << b;
    endfunction

    // Stub checker banks: one-hot of the low code byte, delayed CHK_LAT cycles.
    assign mask0 = onehot(code0[7:0]);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask1 <= '0;
        else        mask1 <= onehot(code1[7:0]);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) d4[k] <= '0;
        end else begin
            d4[0] <= onehot(code4[7:0]);
            for (int k = 1; k < 4; k++) d4[k] <= d4[k-1];
        end
    end
    assign mask4 = d4[3];

    prm_obstacle_scan_ctrl #(.CHK_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .obs_valid_i(obs_valid),
        .obs_ready_o(ready0), .obs_code_i(obs_code), .obs_last_i(obs_last),
        .chk_code_o(code0), .chk_mask_i(mask0), .busy_o(busy0), .done_o(done0),
        .any_blocked_o(any0), .obs_count_o(cnt0), .rd_addr_i(rd_addr), .rd_data_o(rd0)
    );
    prm_obstacle_scan_ctrl #(.CHK_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .obs_valid_i(obs_valid),
        .obs_ready_o(ready1), .obs_code_i(obs_code), .obs_last_i(obs_last),
        .chk_code_o(code1), .chk_mask_i(mask1), .busy_o(busy1), .done_o(done1),
        .any_blocked_o(any1), .obs_count_o(cnt1), .rd_addr_i(rd_addr), .rd_data_o(rd1)
    );
    prm_obstacle_scan_ctrl #(.CHK_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .obs_valid_i(obs_valid),
        .obs_ready_o(ready4), .obs_code_i(obs_code), .obs_last_i(obs_last),
        .chk_code_o(code4), .chk_mask_i(mask4), .busy_o(busy4), .done_o(done4),
        .any_blocked_o(any4), .obs_count_o(cnt4), .rd_addr_i(rd_addr), .rd_data_o(rd4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model (CHK_LAT=1 instance) ----------------
    typedef struct {
        int unsigned  due;
        logic [255:0] mask;
    } pend_t;

    pend_t        pq[$];
    pend_t        pe;
    int unsigned  m_edge;
    int unsigned  m_done_at;
    logic         m_open, m_scan, m_done;
    logic [255:0] m_bitmap;
    logic [31:0]  m_rd;
    logic [15:0]  m_count;
    logic [14:0]  m_code;

    // A code accepted on edge e merges its mask on edge e+LAT+1; the frame closes on
    // edge e+LAT+2 after its last code.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            m_edge = 0; m_done_at = 0; m_open = 0; m_scan = 0; m_done = 0;
            m_bitmap = '0; m_rd = '0; m_count = '0; m_code = '0;
        end else begin
            m_edge++;
            m_rd   = m_bitmap[int'(rd_addr)*32 +: 32];
            m_done = 1'b0;
            if (start) begin
                pq.delete();
                m_bitmap = '0; m_count = '0; m_open = 1; m_scan = 1; m_done_at = 0;
            end else begin
                while (pq.size() > 0 && pq[0].due == m_edge) begin
                    m_bitmap |= pq[0].mask;
                    pq.delete(0);
                end
                if (m_open && !m_scan && m_edge == m_done_at) begin
                    m_open = 0;
                    m_done = 1;
                end
                if (m_scan && obs_valid) begin
                    pe.due  = m_edge + LAT1 + 1;
                    pe.mask = onehot(obs_code[7:0]);
                    pq.push_back(pe);
                    m_code = obs_code;
                    if (m_count != 16'hFFFF) m_count++;
                    if (obs_last) begin
                        m_scan    = 0;
                        m_done_at = m_edge + LAT1 + 2;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [14:0] diff;
            string       cname;
            int          idx;
            diff  = code1 ^ m_code;
            cname = "chk_code";
            if (diff != 0) begin
                idx = 0;
                while (!diff[idx]) idx++;
                cname = $sformatf("chk_code_input_%c", chk_letter(idx));
            end
            check("obs_ready",   {31'd0, ready1}, {31'd0, m_scan && !start});
            check(cname,         {17'd0, code1},  {17'd0, m_code});
            check("busy",        {31'd0, busy1},  {31'd0, m_open});
            check("done",        {31'd0, done1},  {31'd0, m_done});
            check("any_blocked", {31'd0, any1},   {31'd0, |m_bitmap});
            check("obs_count",   {16'd0, cnt1},   {16'd0, m_count});
            check("rd_data",     rd1,             m_rd);
            if (done1) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [14:0] c, input logic l);
        start = s; obs_valid = v; obs_code = c; obs_last = l;
        tick();
        start = 1'b0; obs_valid = 1'b0; obs_last = 1'b0;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done0;
            4:       return done4;
            default: return done1;
        endcase
    endfunction

    task automatic wait_done(input int sel, input int max, output int k);
        k = 0;
        while (done_of(sel) !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        if (done_of(sel) !== 1'b1) check($sformatf("done_timeout_lat%0d", sel), 32'd0, 32'd1);
    endtask

    task automatic read_word(input logic [2:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic scenario1();
        drive(1, 0, 15'h0000, 0);
        drive(0, 1, 15'h0003, 0);
        drive(0, 1, 15'h0005, 0);
        drive(0, 1, 15'h00FF, 1);
    endtask

    initial begin
        int k;
        int dc0;
        logic [31:0] exp_w [8];

        rst_n = 1'b0; start = 1'b0; obs_valid = 1'b0; obs_code = '0; obs_last = 1'b0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("reset_ready", {31'd0, ready1}, 32'd0);
        check("reset_busy",  {31'd0, busy1},  32'd0);
        check("reset_done",  {31'd0, done1},  32'd0);
        check("reset_count", {16'd0, cnt1},   32'd0);
        check("reset_rd",    rd1,             32'd0);
        tick();

        // 1: three back-to-back codes
        dc0 = done_cnt;
        scenario1();
        wait_done(1, 20, k);
        read_word(3'd0);
        check("t1_word0", rd1, 32'h0000_0028);
        read_word(3'd7);
        check("t1_word7", rd1, 32'h8000_0000);
        check("t1_count", {16'd0, cnt1}, 32'd3);
        check("t1_any",   {31'd0, any1}, 32'd1);
        check("t1_done_pulses", done_cnt - dc0, 32'd1);

        // 2: single-beat frame, done latency
        drive(1, 0, 15'h0000, 0);
        drive(0, 1, 15'h7F00, 1);
        wait_done(1, 20, k);
        check("t2_done_latency", k, LAT1 + 2);
        check("t2_busy_at_done", {31'd0, busy1}, 32'd0);
        read_word(3'd0);
        check("t2_word0", rd1, 32'h0000_0001);

        // 3: bubbles, then codes offered while draining and done
        dc0 = done_cnt;
        drive(1, 0, 15'h0000, 0);
        begin
            logic v_pat [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
            for (int i = 0; i < 10; i++) begin
                if (i < 6) drive(0, v_pat[i], 15'(32 + i), 1'(i == 5));
                else       drive(0, v_pat[i], 15'h0040, 0);
            end
        end
        drive(0, 1, 15'h0040, 0);
        drive(0, 1, 15'h0040, 0);
        check("t3_count", {16'd0, cnt1}, 32'd4);
        check("t3_done_pulses", done_cnt - dc0, 32'd1);
        read_word(3'd1);
        check("t3_word1", rd1, 32'h0000_002D);
        read_word(3'd2);
        check("t3_word2", rd1, 32'h0000_0000);

        // 4: abort with tokens in flight
        dc0 = done_cnt;
        rd_addr = 3'd0;
        drive(1, 0, 15'h0000, 0);
        drive(0, 1, 15'h0001, 0);
        drive(0, 1, 15'h0002, 0);
        drive(1, 0, 15'h0000, 0);
        drive(0, 0, 15'h0000, 0);
        drive(0, 0, 15'h0000, 0);
        check("t4_bitmap_cleared", rd1, 32'd0);
        check("t4_no_done", done_cnt - dc0, 32'd0);
        drive(0, 1, 15'h0010, 1);
        wait_done(1, 20, k);
        read_word(3'd0);
        check("t4_word0", rd1, 32'h0001_0000);

        // 5: start collides with a valid beat
        drive(1, 1, 15'h0001, 0);
        check("t5_not_accepted", {16'd0, cnt1}, 32'd0);
        drive(0, 1, 15'h0001, 1);
        check("t5_accepted", {16'd0, cnt1}, 32'd1);
        wait_done(1, 20, k);
        read_word(3'd0);
        check("t5_word0", rd1, 32'h0000_0002);

        // 6: reset during drain, then identical bitmaps across latencies
        dc0 = done_cnt;
        scenario1();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", {31'd0, ready1}, 32'd0);
        check("t6_rst_code",  {17'd0, code1},  32'd0);
        check("t6_rst_busy",  {31'd0, busy1},  32'd0);
        check("t6_rst_done",  {31'd0, done1},  32'd0);
        check("t6_rst_any",   {31'd0, any1},   32'd0);
        check("t6_rst_count", {16'd0, cnt1},   32'd0);
        check("t6_rst_rd",    rd1,             32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) tick();
        check("t6_no_done", done_cnt - dc0, 32'd0);
        scenario1();
        wait_done(4, 30, k);
        exp_w = '{32'h0000_0028, 0, 0, 0, 0, 0, 0, 32'h8000_0000};
        for (int w = 0; w < 8; w++) begin
            read_word(3'(w));
            check($sformatf("t6_lat0_word%0d", w), rd0, exp_w[w]);
            check($sformatf("t6_lat1_word%0d", w), rd1, exp_w[w]);
            check($sformatf("t6_lat4_word%0d", w), rd4, exp_w[w]);
        end

        // 7: obs_count saturation, frame still completes
        drive(1, 0, 15'h0000, 0);
        for (int i = 0; i < 65540; i++) drive(0, 1, 15'h0007, 0);
        check("t7_saturated", {16'd0, cnt1}, 32'h0000_FFFF);
        drive(0, 1, 15'h0009, 1);
        check("t7_still_saturated", {16'd0, cnt1}, 32'h0000_FFFF);
        wait_done(1, 20, k);
        read_word(3'd0);
        check("t7_word0", rd1, 32'h0000_0280);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
